fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding decode. Owns the PC, keeps at most one
//   read outstanding to instruction memory and presents one registered
//   instruction word (plus its PC) to decode. A redirect from execute flushes
//   everything in flight and restarts fetch at the new target.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   imem_req_valid/addr fetch request (word aligned), accepted when ready=1
//   imem_req_ready      memory accepts the request this cycle
//   imem_resp_valid/data read data for the outstanding request
//   redirect_valid/pc   flush and restart fetch at redirect_pc (bits [1:0] dropped)
//   stall               decode cannot take a new instruction this cycle
//   inst_valid/inst/inst_pc  registered instruction slot towards decode
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, req_pc;
    logic        kill;          // outstanding response belongs to a flushed path
    logic        buf_valid;
    logic [31:0] buf_data, buf_pc;

    logic        accept;
    logic        slot_free;
    logic        resp_live;

    // A request seen together with a redirect is dropped by the memory side,
    // so it is never recorded as accepted here either.
    assign accept    = imem_req_valid & imem_req_ready & ~redirect_valid;
    assign slot_free = ~inst_valid | ~stall;
    assign resp_live = (state == S_WAIT) & imem_resp_valid & ~kill;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_REQ;
        else          state <= state_nxt;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            case (state)
                S_REQ:   state_nxt = S_REQ;
                S_WAIT:  state_nxt = imem_resp_valid ? S_REQ : S_WAIT;
                S_HOLD:  state_nxt = S_REQ;
                default: state_nxt = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ:   if (accept) state_nxt = S_WAIT;
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (kill || slot_free) state_nxt = S_REQ;
                        else                   state_nxt = S_HOLD;
                    end
                end
                S_HOLD:  if (!stall) state_nxt = S_REQ;
                default: state_nxt = S_REQ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    // Request valid is gated by reset_n so nothing is requested in the
    // cycle reset is asserted, before the state register has been reset.
    always_comb begin
        imem_req_valid = reset_n && (state == S_REQ);
        imem_req_addr  = pc;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            req_pc     <= '0;
            kill       <= 1'b0;
            buf_valid  <= 1'b0;
            buf_data   <= '0;
            buf_pc     <= '0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else if (redirect_valid) begin
            // Flush beats stall: the slot is emptied even while decode stalls.
            pc         <= {redirect_pc[31:2], 2'b00};
            inst_valid <= 1'b0;
            buf_valid  <= 1'b0;
            // Only a still-pending response needs to be killed; one arriving
            // this very edge is simply dropped.
            kill       <= (state == S_WAIT) && !imem_resp_valid;
        end else begin
            if (accept) begin
                req_pc <= pc;
                pc     <= pc + 32'd4;
            end

            if ((state == S_WAIT) && imem_resp_valid && kill)
                kill <= 1'b0;

            if (resp_live && !slot_free) begin
                buf_data  <= imem_resp_data;
                buf_pc    <= req_pc;
                buf_valid <= 1'b1;
            end

            if (resp_live && slot_free) begin
                inst       <= imem_resp_data;
                inst_pc    <= req_pc;
                inst_valid <= 1'b1;
            end else if ((state == S_HOLD) && !stall) begin
                inst       <= buf_data;
                inst_pc    <= buf_pc;
                inst_valid <= buf_valid;
                buf_valid  <= 1'b0;
            end else if (!stall) begin
                // Word consumed by decode; data/pc are left stale.
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Bench for fetch_unit. A behavioural instruction memory answers each
//   accepted request after mem_lat cycles with addr ^ 32'hA5A5_0000.
//   Accepted requests push the expected {pc, word} onto a scoreboard; redirect
//   and reset squash it; each instruction taken by decode (inst_valid & !stall)
//   pops and compares. Redirect targets are swept from a vector table.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_2000)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
    } vec_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    int          mem_lat     = 1;
    logic        mem_pending = 1'b0;
    int          mem_cnt     = 0;
    logic [31:0] mem_addr    = '0;

    logic        last_acc  = 1'b0;
    logic [31:0] last_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    // One clock cycle: called just after an edge with inputs set for the
    // coming edge. Observes the pre-edge state, then advances the memory.
    task automatic cyc();
        logic        acc;
        logic [31:0] a;
        logic        consumed;
        exp_t        e;
        #1;
        acc      = reset_n && imem_req_valid && imem_req_ready && !redirect_valid;
        a        = imem_req_addr;
        consumed = imem_resp_valid;
        if (reset_n && !redirect_valid && inst_valid && !stall) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected: got inst_pc %h, want no instruction", inst_pc);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", inst_pc, e.pc);
                chk("sb_data", inst, e.data);
            end
        end
        if (acc) begin
            chk1("one_outstanding", mem_pending, 1'b0);
            sb.push_back('{pc: a, data: a ^ K});
        end
        if (redirect_valid || !reset_n) sb.delete();

        @(posedge clk);
        #1;
        last_acc  = acc;
        last_addr = a;
        if (consumed) begin
            imem_resp_valid = 1'b0;
            mem_pending     = 1'b0;
        end
        if (acc) begin
            mem_pending = 1'b1;
            mem_addr    = a;
            mem_cnt     = mem_lat;
        end
        if (mem_pending && !imem_resp_valid) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_addr ^ K;
            end
        end
    endtask

    task automatic wait_acc(input string name, input logic [31:0] exp);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!last_acc && n < 20);
        chk(name, last_acc ? last_addr : 32'hDEAD_BEEF, exp);
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        repeat (n) cyc();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[5];
        int   nacc, bad, n;

        vt[0] = '{rpc: 32'h0000_3007, exp_addr: 32'h0000_3004, exp_next: 32'h0000_3008};
        vt[1] = '{rpc: 32'hFFFF_FFFC, exp_addr: 32'hFFFF_FFFC, exp_next: 32'h0000_0000};
        vt[2] = '{rpc: 32'h0000_1001, exp_addr: 32'h0000_1000, exp_next: 32'h0000_1004};
        vt[3] = '{rpc: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC, exp_next: 32'h0000_0000};
        vt[4] = '{rpc: 32'h0000_0002, exp_addr: 32'h0000_0000, exp_next: 32'h0000_0004};

        reset_n         = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        stall           = 1'b0;

        // ---- reset state, then straight-line fetch with 1-cycle memory ----
        mem_lat = 1;
        repeat (3) cyc();
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_pc", imem_req_addr, 32'h0000_2000);
        reset_n = 1'b1;
        cyc();
        chk("s1_acc0", last_acc ? last_addr : 32'hDEAD_BEEF, 32'h0000_2000);
        chk1("s1_iv_e1", inst_valid, 1'b0);
        cyc();
        chk1("s1_iv_e2", inst_valid, 1'b1);
        chk("s1_pc_e2", inst_pc, 32'h0000_2000);
        chk("s1_inst_e2", inst, 32'h0000_2000 ^ K);
        wait_acc("s1_acc1", 32'h0000_2004);
        wait_acc("s1_acc2", 32'h0000_2008);
        repeat (3) cyc();

        // ---- stall held 5 cycles: second word buffered, no third request ----
        do_reset(4);
        wait_acc("s2_acc0", 32'h0000_2000);
        cyc();
        chk1("s2_iv", inst_valid, 1'b1);
        stall = 1'b1;
        nacc  = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (last_acc) begin
                nacc++;
                chk("s2_acc_stall", last_addr, 32'h0000_2004);
            end
            chk("s2_hold_pc", inst_pc, 32'h0000_2000);
            chk("s2_hold_inst", inst, 32'h0000_2000 ^ K);
        end
        chk("s2_nacc", 32'(nacc), 32'd1);
        chk1("s2_no_req", imem_req_valid, 1'b0);
        stall = 1'b0;
        cyc();
        chk1("s2_rel_iv", inst_valid, 1'b1);
        chk("s2_rel_pc", inst_pc, 32'h0000_2004);
        chk("s2_rel_inst", inst, 32'h0000_2004 ^ K);
        cyc();
        chk("s2_acc2", last_acc ? last_addr : 32'hDEAD_BEEF, 32'h0000_2008);
        repeat (3) cyc();

        // ---- latency 3: redirect while 0x2004 is in flight ----
        mem_lat = 3;
        do_reset(4);
        wait_acc("s3_acc0", 32'h0000_2000);
        wait_acc("s3_acc1", 32'h0000_2004);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_4000;
        cyc();
        redirect_valid = 1'b0;
        bad = 0;
        n   = 0;
        do begin
            if (inst_valid) bad++;
            cyc();
            n++;
        end while (!last_acc && n < 15);
        chk("s3_squash", 32'(bad), 32'd0);
        chk("s3_next", last_acc ? last_addr : 32'hDEAD_BEEF, 32'h0000_4000);
        repeat (6) cyc();

        // ---- redirect in the same cycle as the response ----
        mem_lat = 2;
        do_reset(4);
        wait_acc("s4_acc0", 32'h0000_2000);
        n = 0;
        while (!imem_resp_valid && n < 10) begin
            cyc();
            n++;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_5000;
        cyc();
        redirect_valid = 1'b0;
        chk1("s4_iv", inst_valid, 1'b0);
        chk1("s4_req_valid", imem_req_valid, 1'b1);
        chk("s4_req_addr", imem_req_addr, 32'h0000_5000);
        wait_acc("s4_acc1", 32'h0000_5000);
        repeat (4) cyc();

        // ---- redirect target table: alignment and wrap ----
        mem_lat = 1;
        for (int i = 0; i < 5; i++) begin
            imem_req_ready = 1'b0;
            repeat (4) cyc();
            redirect_valid = 1'b1;
            redirect_pc    = vt[i].rpc;
            cyc();
            redirect_valid = 1'b0;
            chk1($sformatf("vec%0d_iv", i), inst_valid, 1'b0);
            chk1($sformatf("vec%0d_req_valid", i), imem_req_valid, 1'b1);
            chk($sformatf("vec%0d_addr", i), imem_req_addr, vt[i].exp_addr);
            imem_req_ready = 1'b1;
            wait_acc($sformatf("vec%0d_acc0", i), vt[i].exp_addr);
            wait_acc($sformatf("vec%0d_acc1", i), vt[i].exp_next);
        end

        // ---- reset while waiting on a latency-3 response ----
        mem_lat = 3;
        wait_acc("s7_acc", vt[4].exp_next + 32'd4);
        reset_n = 1'b0;
        cyc();
        chk1("s7_rst_iv", inst_valid, 1'b0);
        chk("s7_rst_inst", inst, 32'h0);
        chk("s7_rst_pc", inst_pc, 32'h0);
        chk1("s7_rst_req", imem_req_valid, 1'b0);
        repeat (4) cyc();
        chk1("s7_rst_iv2", inst_valid, 1'b0);
        reset_n = 1'b1;
        wait_acc("s7_restart", 32'h0000_2000);
        imem_req_ready = 1'b0;
        repeat (6) cyc();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
